multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle variant of the processor.
- Sequences the shared datapath (PC, IR, memory, register file, ALU) through fetch, decode, execute, memory and writeback steps, one state per clock.
- Supports a memory ready handshake so the core can stall on slow memory.
- Exposes its current state and a retired-instruction counter for bench and debug visibility.

---
 rtl/multicycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, stalls on MemReady and counts retired instructions.
module multicycle_ctrl #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_ADDI = 6'b001000,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter int         CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             Illegal,
  output logic [3:0]       StateOut,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; retire marks a terminal state handing control back to FETCH.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW)) state_d = S_MEMADR;
        else if (Op == OP_R)                state_d = S_EXECUTE;
        else if (Op == OP_BEQ)              state_d = S_BRANCH;
        else if (Op == OP_ADDI)             state_d = S_ADDIEX;
        else if (Op == OP_J)                state_d = S_JUMP;
        else                                state_d = S_FETCH;
      end
      S_MEMADR: begin
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Moore decode of the registered state; only FETCH's PC/IR loads wait on MemReady.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    Illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !op_legal(Op);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
    if (RST) begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      Illegal  = 1'b0;
    end
  end

  assign StateOut   = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors push expected state,
// control word and count; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  Op;
  logic        MemReady;
  logic        PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  StateOut;
  logic [15:0] InstrCount;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .Illegal(Illegal), .StateOut(StateOut), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Control word: {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,
  //                RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,Illegal}
  function automatic logic [16:0] pack(
    input logic pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca,
    input logic [1:0] srcb, aop, pcs, input logic ill);
    return {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, ill};
  endfunction

  // Table of required outputs for each state of the control flow.
  function automatic logic [16:0] want(input logic rst, input logic [3:0] st,
                                       input logic mr, input logic [5:0] op);
    logic ill;
    ill = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
            op == OP_ADDI || op == OP_J);
    if (rst) return '0;
    case (st)
      4'd0:  return pack(mr,0,0,1,0,mr,0,0,0,0, 2'b01,2'b00,2'b00, 0);
      4'd1:  return pack(0,0,0,0,0,0,0,0,0,0,   2'b11,2'b00,2'b00, ill);
      4'd2:  return pack(0,0,0,0,0,0,0,0,0,1,   2'b10,2'b00,2'b00, 0);
      4'd3:  return pack(0,0,1,1,0,0,0,0,0,0,   2'b00,2'b00,2'b00, 0);
      4'd4:  return pack(0,0,0,0,0,0,0,1,1,0,   2'b00,2'b00,2'b00, 0);
      4'd5:  return pack(0,0,1,0,1,0,0,0,0,0,   2'b00,2'b00,2'b00, 0);
      4'd6:  return pack(0,0,0,0,0,0,0,0,0,1,   2'b00,2'b10,2'b00, 0);
      4'd7:  return pack(0,0,0,0,0,0,1,0,1,0,   2'b00,2'b00,2'b00, 0);
      4'd8:  return pack(0,1,0,0,0,0,0,0,0,1,   2'b00,2'b01,2'b01, 0);
      4'd9:  return pack(0,0,0,0,0,0,0,0,0,1,   2'b10,2'b00,2'b00, 0);
      4'd10: return pack(0,0,0,0,0,0,0,0,1,0,   2'b00,2'b00,2'b00, 0);
      4'd11: return pack(1,0,0,0,0,0,0,0,0,0,   2'b00,2'b00,2'b10, 0);
      default: return '0;
    endcase
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show during it.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [15:0] cnt);
    exp_t e;
    RST      = rst;
    Op       = op;
    MemReady = mr;
    e.st   = st;
    e.ctrl = want(rst, st, mr, op);
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [16:0] got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal};
        checks++;
        if (StateOut !== e.st) begin
          errors++;
          $display("FAIL state t=%0t got=%0d exp=%0d", $time, StateOut, e.st);
        end
        checks++;
        if (got !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl t=%0t state=%0d got=%b exp=%b", $time, e.st, got, e.ctrl);
        end
        checks++;
        if (InstrCount !== e.cnt) begin
          errors++;
          $display("FAIL count t=%0t got=%0d exp=%0d", $time, InstrCount, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    RST = 1'b1; Op = OP_R; MemReady = 1'b1;
    @(posedge CLK);
    #1;
    // reset held two cycles, then FETCH with MemReady
    step(1, OP_R, 1, 0, 0);
    step(1, OP_R, 1, 0, 0);
    // R-type
    step(0, OP_R, 1, 0, 0);
    step(0, OP_R, 1, 1, 0);
    step(0, OP_R, 1, 6, 0);
    step(0, OP_R, 1, 7, 0);
    // LW with two stall cycles in MEMRD
    step(0, OP_LW, 1, 0, 1);
    step(0, OP_LW, 1, 1, 1);
    step(0, OP_LW, 1, 2, 1);
    step(0, OP_LW, 0, 3, 1);
    step(0, OP_LW, 0, 3, 1);
    step(0, OP_LW, 1, 3, 1);
    step(0, OP_LW, 1, 4, 1);
    // SW with one wait in MEMWR, then BEQ, then J
    step(0, OP_SW, 1, 0, 2);
    step(0, OP_SW, 1, 1, 2);
    step(0, OP_SW, 1, 2, 2);
    step(0, OP_SW, 0, 5, 2);
    step(0, OP_SW, 1, 5, 2);
    step(0, OP_BEQ, 1, 0, 3);
    step(0, OP_BEQ, 1, 1, 3);
    step(0, OP_BEQ, 1, 8, 3);
    step(0, OP_J, 1, 0, 4);
    step(0, OP_J, 1, 1, 4);
    step(0, OP_J, 1, 11, 4);
    // illegal opcode: not counted
    step(0, OP_BAD, 1, 0, 5);
    step(0, OP_BAD, 1, 1, 5);
    // fetch stall, then ADDI
    step(0, OP_ADDI, 0, 0, 5);
    step(0, OP_ADDI, 0, 0, 5);
    step(0, OP_ADDI, 1, 0, 5);
    step(0, OP_ADDI, 1, 1, 5);
    step(0, OP_ADDI, 1, 9, 5);
    step(0, OP_ADDI, 1, 10, 5);
    // LW aborted by reset while stalled in MEMRD
    step(0, OP_LW, 1, 0, 6);
    step(0, OP_LW, 1, 1, 6);
    step(0, OP_LW, 1, 2, 6);
    step(0, OP_LW, 0, 3, 6);
    step(1, OP_LW, 0, 3, 6);
    step(0, OP_LW, 1, 0, 0);
    step(0, OP_LW, 1, 1, 0);
    repeat (5) begin
      if (exp_q.size() != 0) @(posedge CLK);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
